regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Buffers ROB/commit writebacks and drives the regfile's two write ports.
//  Accepts up to 2 writebacks per cycle into an in-order queue and issues up to 2 per cycle.
//  Drops writes to x0.
//  Splits same-target pairs so the two write ports never hit one register in the same cycle.
//  Sits between commit logic and regfile (rob_WB_target/data/en 1 and 2).
// PARAMETERS
//  OPRAND_WIDTH   16  data width of one writeback
//  REGNAME_WIDTH  5   architectural register index width
//  QUEUE_DEPTH    8   queue entries; power of two, >= 4
// PORTS
//  clk            in   1              clock; all state updates on rising edge
//  rst            in   1              reset; synchronous, active-low
//  in0_valid      in   1              lane-0 writeback request (older of the pair)
//  in0_target     in   REGNAME_WIDTH  lane-0 destination register
//  in0_data       in   OPRAND_WIDTH   lane-0 result
//  in1_valid      in   1              lane-1 writeback request (younger)
//  in1_target     in   REGNAME_WIDTH  lane-1 destination register
//  in1_data       in   OPRAND_WIDTH   lane-1 result
//  in_ready       out  1              1 = at least 2 free entries; both lanes may enqueue this cycle
//  wb_stall       in   1              1 = freeze issue; no writes go to the regfile next cycle
//  rob_WB_en1     out  1              regfile write-port-1 enable (older entry)
//  rob_WB_target1 out  REGNAME_WIDTH  regfile write-port-1 address
//  rob_WB_data1   out  OPRAND_WIDTH   regfile write-port-1 data
//  rob_WB_en2     out  1              regfile write-port-2 enable (younger entry)
//  rob_WB_target2 out  REGNAME_WIDTH  regfile write-port-2 address
//  rob_WB_data2   out  OPRAND_WIDTH   regfile write-port-2 data
//  q_count        out  $clog2(QUEUE_DEPTH)+1  current queue occupancy
//  q_empty        out  1              q_count == 0
// BEHAVIOUR
//  Reset (rst==0 at edge):
//   - head/tail pointers = 0, q_count = 0.
//   - All rob_WB_* outputs = 0; in_ready = 1, q_empty = 1.
//   - Any in-flight queue contents are discarded.
//  Enqueue:
//   - A lane is accepted at the edge when valid && in_ready && target != 0.
//   - Lane 0 is written at tail, then lane 1; tail advances by the number accepted (0..2).
//   - Valid with target == 0 is consumed and discarded, never stored.
//   - in1 alone is legal and takes one slot.
//   - Valid while in_ready == 0 is ignored; the producer must hold the request.
//   - in_ready is combinational from the registered count: (QUEUE_DEPTH - q_count) >= 2.
//  Issue (each edge, if wb_stall == 0):
//   - Head entry goes to port 1; head+1 goes to port 2 only if it exists and head+1.target != head.target.
//   - Head advances by the number issued (0..2).
//   - The rob_WB_* output regs load the selection, with en = 0 for any port left empty.
//   - Same-target pair: only the head is issued this cycle; head+1 issues on port 1 next edge.
//     Order is always preserved.
//   - wb_stall == 1: no pop; both en regs load 0; target/data regs hold their values.
//  Latency: a request presented in cycle N (edge N) has its en asserted in cycle N+2.
//   - The queue is never bypassed.
//  Count:
//   - q_count_next = q_count + enq - deq. Enqueue and dequeue in the same edge are legal.
//   - When the queue is full, a simultaneous pop does not raise in_ready in the same cycle.
//  Pointers wrap modulo QUEUE_DEPTH; full/empty are derived from q_count, not pointer equality.
//  Must never overflow; an assertion fires if an enqueue would exceed QUEUE_DEPTH.
//  An entry is issued exactly once; no entry is dropped except target == 0.
// TESTING
//  1 Reset:
//    - Stimulus: hold rst=0 for 2 edges with in0_valid=1.
//    - Required: en1 = en2 = 0, q_count = 0, in_ready = 1; nothing issued after release.
//  2 Dual issue:
//    - Stimulus: one cycle with in0 = (r3, 0x1111), in1 = (r4, 0x2222).
//    - Required: 2 cycles later en1 = en2 = 1, target1 = 3 / data1 = 0x1111, target2 = 4 / data2 = 0x2222.
//  3 Conflict split:
//    - Stimulus: in0 = (r5, 0xAAAA), in1 = (r5, 0xBBBB).
//    - Required: cycle+2 only en1 with 0xAAAA; cycle+3 en1 with 0xBBBB; en2 = 0 in both.
//  4 x0 drop:
//    - Stimulus: in0 = (r0, 0xFFFF), in1 = (r7, 0x0007).
//    - Required: q_count becomes 1; only r7 is ever issued, on port 1.
//  5 Full/backpressure:
//    - Stimulus: wb_stall=1; enqueue 8 distinct targets (4 dual cycles).
//    - Required: in_ready = 0 at q_count = 7 and 8; held requests are not lost.
//    - After wb_stall=0: 8 writes issue in order over 4 cycles; wrap-around exercised.
//  6 Mid-operation reset:
//    - Stimulus: q_count = 5; assert rst for 1 edge.
//    - Required: next cycle q_count = 0, en1 = en2 = 0; no stale entries issued afterwards.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Buffers commit writebacks in an in-order queue and drives the two regfile
//   write ports. The queue takes up to two writebacks per cycle and issues up
//   to two per cycle. Writes to x0 are dropped. When the two oldest entries
//   name the same register, they are issued on consecutive cycles, so the two
//   ports never write one register in the same cycle.
//
//   Ports:
//     clk, rst            clock; synchronous active-low reset
//     in0_*               older writeback lane (valid/target/data)
//     in1_*               younger writeback lane (valid/target/data)
//     in_ready            at least two free entries; both lanes may enqueue
//     wb_stall            freeze issue; both enables go low next cycle
//     rob_WB_en1/target1/data1   write port 1 (older entry), registered
//     rob_WB_en2/target2/data2   write port 2 (younger entry), registered
//     q_count, q_empty    queue occupancy and empty flag

module regfile_wb_scheduler #(
  parameter int OPRAND_WIDTH  = 16,
  parameter int REGNAME_WIDTH = 5,
  parameter int QUEUE_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in0_valid,
  input  logic [REGNAME_WIDTH-1:0]       in0_target,
  input  logic [OPRAND_WIDTH-1:0]        in0_data,
  input  logic                           in1_valid,
  input  logic [REGNAME_WIDTH-1:0]       in1_target,
  input  logic [OPRAND_WIDTH-1:0]        in1_data,
  output logic                           in_ready,
  input  logic                           wb_stall,
  output logic                           rob_WB_en1,
  output logic [REGNAME_WIDTH-1:0]       rob_WB_target1,
  output logic [OPRAND_WIDTH-1:0]        rob_WB_data1,
  output logic                           rob_WB_en2,
  output logic [REGNAME_WIDTH-1:0]       rob_WB_target2,
  output logic [OPRAND_WIDTH-1:0]        rob_WB_data2,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count,
  output logic                           q_empty
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [REGNAME_WIDTH-1:0] X0_C = {REGNAME_WIDTH{1'b0}};

  logic [REGNAME_WIDTH-1:0] tgt_mem_r  [QUEUE_DEPTH];
  logic [OPRAND_WIDTH-1:0]  data_mem_r [QUEUE_DEPTH];
  logic [PW-1:0]            head_r;
  logic [PW-1:0]            tail_r;
  logic [CW-1:0]            count_r;

  logic [CW-1:0] free_s;
  logic          acc0_s;
  logic          acc1_s;
  logic [1:0]    enq_cnt_s;
  logic [PW-1:0] tail1_s;
  logic [PW-1:0] head1_s;
  logic          iss0_s;
  logic          iss1_s;
  logic [1:0]    deq_cnt_s;
  logic [CW-1:0] count_next_s;

  // Acceptance, issue selection and occupancy update.
  always_comb begin
    free_s    = DEPTH_C - count_r;
    in_ready  = (free_s >= CW'(2));
    // Valid x0 writes are consumed (never stored) simply by not counting them.
    acc0_s    = in0_valid && in_ready && (in0_target != X0_C);
    acc1_s    = in1_valid && in_ready && (in1_target != X0_C);
    enq_cnt_s = {1'b0, acc0_s} + {1'b0, acc1_s};
    // Lane 1 lands directly behind lane 0, or at tail when lane 0 is not stored.
    tail1_s   = tail_r + PW'(acc0_s);
    head1_s   = head_r + PW'(1);
    if (wb_stall) begin
      iss0_s = 1'b0;
      iss1_s = 1'b0;
    end else begin
      iss0_s = (count_r != CW'(0));
      // Second entry only if present and not aimed at the head's register.
      iss1_s = (count_r >= CW'(2)) && (tgt_mem_r[head1_s] != tgt_mem_r[head_r]);
    end
    deq_cnt_s    = {1'b0, iss0_s} + {1'b0, iss1_s};
    count_next_s = count_r + CW'(enq_cnt_s) - CW'(deq_cnt_s);
  end

  // Queue storage writes; contents need no reset because occupancy gates use.
  always_ff @(posedge clk) begin
    if (rst && acc0_s) begin
      tgt_mem_r[tail_r]  <= in0_target;
      data_mem_r[tail_r] <= in0_data;
    end
    if (rst && acc1_s) begin
      tgt_mem_r[tail1_s]  <= in1_target;
      data_mem_r[tail1_s] <= in1_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      head_r  <= head_r + PW'(deq_cnt_s);
      tail_r  <= tail_r + PW'(enq_cnt_s);
      count_r <= count_next_s;
    end
  end

  // Registered write-port outputs; target/data hold when a port is left idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rob_WB_en1     <= 1'b0;
      rob_WB_target1 <= {REGNAME_WIDTH{1'b0}};
      rob_WB_data1   <= {OPRAND_WIDTH{1'b0}};
      rob_WB_en2     <= 1'b0;
      rob_WB_target2 <= {REGNAME_WIDTH{1'b0}};
      rob_WB_data2   <= {OPRAND_WIDTH{1'b0}};
    end else begin
      rob_WB_en1 <= iss0_s;
      rob_WB_en2 <= iss1_s;
      if (iss0_s) begin
        rob_WB_target1 <= tgt_mem_r[head_r];
        rob_WB_data1   <= data_mem_r[head_r];
      end
      if (iss1_s) begin
        rob_WB_target2 <= tgt_mem_r[head1_s];
        rob_WB_data2   <= data_mem_r[head1_s];
      end
    end
  end

  // Occupancy outputs follow the registered count.
  always_comb begin
    q_count = count_r;
    q_empty = (count_r == CW'(0));
  end

  regfile_wb_scheduler_chk #(
    .CW          (CW),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .count     (count_r),
    .enq_cnt   (enq_cnt_s),
    .deq_cnt   (deq_cnt_s)
  );

endmodule

// regfile_wb_scheduler_chk
//   Occupancy invariants: an enqueue never pushes the queue past its depth,
//   and nothing is popped that is not present.
//   Ports: clk, rst, count (current occupancy), enq_cnt, deq_cnt.
module regfile_wb_scheduler_chk #(
  parameter int CW          = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count,
  input logic [1:0]    enq_cnt,
  input logic [1:0]    deq_cnt
);

  // Overflow guard on every enqueue edge.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (int'(count) + int'(enq_cnt)) <= QUEUE_DEPTH);

  // Underflow guard on every issue edge.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    int'(deq_cnt) <= int'(count));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset, dual issue, conflict split,
// x0 drop, full/backpressure with wrap-around and mid-operation reset.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        in0_valid;
  logic [4:0]  in0_target;
  logic [15:0] in0_data;
  logic        in1_valid;
  logic [4:0]  in1_target;
  logic [15:0] in1_data;
  logic        in_ready;
  logic        wb_stall;
  logic        rob_WB_en1;
  logic [4:0]  rob_WB_target1;
  logic [15:0] rob_WB_data1;
  logic        rob_WB_en2;
  logic [4:0]  rob_WB_target2;
  logic [15:0] rob_WB_data2;
  logic [3:0]  q_count;
  logic        q_empty;

  int checks;
  int failures;

  regfile_wb_scheduler #(
    .OPRAND_WIDTH  (16),
    .REGNAME_WIDTH (5),
    .QUEUE_DEPTH   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in0_valid      (in0_valid),
    .in0_target     (in0_target),
    .in0_data       (in0_data),
    .in1_valid      (in1_valid),
    .in1_target     (in1_target),
    .in1_data       (in1_data),
    .in_ready       (in_ready),
    .wb_stall       (wb_stall),
    .rob_WB_en1     (rob_WB_en1),
    .rob_WB_target1 (rob_WB_target1),
    .rob_WB_data1   (rob_WB_data1),
    .rob_WB_en2     (rob_WB_en2),
    .rob_WB_target2 (rob_WB_target2),
    .rob_WB_data2   (rob_WB_data2),
    .q_count        (q_count),
    .q_empty        (q_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] t0, input logic [15:0] d0,
                       input logic v1, input logic [4:0] t1, input logic [15:0] d1);
    in0_valid = v0; in0_target = t0; in0_data = d0;
    in1_valid = v1; in1_target = t1; in1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wb_stall = 1'b0;
    drive(1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0000);
    tick();
    tick();
    checks++; if (rob_WB_en1 !== 1'b0) begin failures++; $display("FAIL reset_en1 got=%b exp=0", rob_WB_en1); end
    checks++; if (rob_WB_en2 !== 1'b0) begin failures++; $display("FAIL reset_en2 got=%b exp=0", rob_WB_en2); end
    checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", q_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (q_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", q_empty); end
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rob_WB_en1 !== 1'b0 || q_count !== 4'd0) begin
        failures++; $display("FAIL reset_release cyc=%0d en1=%b count=%0d exp en1=0 count=0", i, rob_WB_en1, q_count);
      end
    end
  endtask

  task automatic test_dual_issue();
    drive(1'b1, 5'd3, 16'h1111, 1'b1, 5'd4, 16'h2222);
    tick();
    idle();
    checks++; if (q_count !== 4'd2 || rob_WB_en1 !== 1'b0) begin
      failures++; $display("FAIL dual_enq count=%0d en1=%b exp count=2 en1=0", q_count, rob_WB_en1);
    end
    tick();
    checks++; if (rob_WB_en1 !== 1'b1 || rob_WB_target1 !== 5'd3 || rob_WB_data1 !== 16'h1111) begin
      failures++; $display("FAIL dual_port1 en=%b t=%0d d=%h exp en=1 t=3 d=1111", rob_WB_en1, rob_WB_target1, rob_WB_data1);
    end
    checks++; if (rob_WB_en2 !== 1'b1 || rob_WB_target2 !== 5'd4 || rob_WB_data2 !== 16'h2222) begin
      failures++; $display("FAIL dual_port2 en=%b t=%0d d=%h exp en=1 t=4 d=2222", rob_WB_en2, rob_WB_target2, rob_WB_data2);
    end
    checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL dual_drain count=%0d exp=0", q_count); end
    tick();
    checks++; if (rob_WB_en1 !== 1'b0 || rob_WB_en2 !== 1'b0) begin
      failures++; $display("FAIL dual_after en1=%b en2=%b exp 0 0", rob_WB_en1, rob_WB_en2);
    end
  endtask

  task automatic test_conflict_split();
    drive(1'b1, 5'd5, 16'hAAAA, 1'b1, 5'd5, 16'hBBBB);
    tick();
    idle();
    tick();
    checks++; if (rob_WB_en1 !== 1'b1 || rob_WB_target1 !== 5'd5 || rob_WB_data1 !== 16'hAAAA || rob_WB_en2 !== 1'b0) begin
      failures++; $display("FAIL split_first en1=%b t1=%0d d1=%h en2=%b exp 1 5 aaaa 0", rob_WB_en1, rob_WB_target1, rob_WB_data1, rob_WB_en2);
    end
    checks++; if (q_count !== 4'd1) begin failures++; $display("FAIL split_count got=%0d exp=1", q_count); end
    tick();
    checks++; if (rob_WB_en1 !== 1'b1 || rob_WB_target1 !== 5'd5 || rob_WB_data1 !== 16'hBBBB || rob_WB_en2 !== 1'b0) begin
      failures++; $display("FAIL split_second en1=%b t1=%0d d1=%h en2=%b exp 1 5 bbbb 0", rob_WB_en1, rob_WB_target1, rob_WB_data1, rob_WB_en2);
    end
    tick();
    checks++; if (rob_WB_en1 !== 1'b0 || q_empty !== 1'b1) begin
      failures++; $display("FAIL split_after en1=%b empty=%b exp 0 1", rob_WB_en1, q_empty);
    end
  endtask

  task automatic test_x0_drop();
    drive(1'b1, 5'd0, 16'hFFFF, 1'b1, 5'd7, 16'h0007);
    tick();
    idle();
    checks++; if (q_count !== 4'd1) begin failures++; $display("FAIL x0_count got=%0d exp=1", q_count); end
    tick();
    checks++; if (rob_WB_en1 !== 1'b1 || rob_WB_target1 !== 5'd7 || rob_WB_data1 !== 16'h0007 || rob_WB_en2 !== 1'b0) begin
      failures++; $display("FAIL x0_issue en1=%b t1=%0d d1=%h en2=%b exp 1 7 0007 0", rob_WB_en1, rob_WB_target1, rob_WB_data1, rob_WB_en2);
    end
    tick();
    checks++; if (rob_WB_en1 !== 1'b0 || q_count !== 4'd0) begin
      failures++; $display("FAIL x0_after en1=%b count=%0d exp 0 0", rob_WB_en1, q_count);
    end
  endtask

  task automatic test_full_backpressure();
    logic [4:0] exp_t [10];
    logic [3:0] exp_c [5];
    for (int i = 0; i < 8; i++) exp_t[i] = 5'(10 + i);
    exp_t[8] = 5'd20;
    exp_t[9] = 5'd21;
    exp_c[0] = 4'd6; exp_c[1] = 4'd6; exp_c[2] = 4'd4; exp_c[3] = 4'd2; exp_c[4] = 4'd0;
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (in_ready !== 1'b1 || q_count !== 4'(2 * k)) begin
        failures++; $display("FAIL fill_ready k=%0d ready=%b count=%0d exp 1 %0d", k, in_ready, q_count, 2 * k);
      end
      drive(1'b1, 5'(10 + 2 * k), 16'h1000 + 16'(10 + 2 * k),
            1'b1, 5'(11 + 2 * k), 16'h1000 + 16'(11 + 2 * k));
      tick();
    end
    // Producer holds an extra pair while the queue is full.
    drive(1'b1, 5'd20, 16'h1000 + 16'd20, 1'b1, 5'd21, 16'h1000 + 16'd21);
    checks++; if (q_count !== 4'd8 || in_ready !== 1'b0 || rob_WB_en1 !== 1'b0) begin
      failures++; $display("FAIL full_state count=%0d ready=%b en1=%b exp 8 0 0", q_count, in_ready, rob_WB_en1);
    end
    tick();
    tick();
    checks++; if (q_count !== 4'd8 || in_ready !== 1'b0 || rob_WB_en1 !== 1'b0 || rob_WB_en2 !== 1'b0) begin
      failures++; $display("FAIL full_hold count=%0d ready=%b en1=%b en2=%b exp 8 0 0 0", q_count, in_ready, rob_WB_en1, rob_WB_en2);
    end
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) idle();
      checks++; if (rob_WB_en1 !== 1'b1 || rob_WB_target1 !== exp_t[2 * i] || rob_WB_data1 !== (16'h1000 + 16'(exp_t[2 * i]))) begin
        failures++; $display("FAIL drain_p1 i=%0d en=%b t=%0d d=%h exp t=%0d", i, rob_WB_en1, rob_WB_target1, rob_WB_data1, exp_t[2 * i]);
      end
      checks++; if (rob_WB_en2 !== 1'b1 || rob_WB_target2 !== exp_t[2 * i + 1] || rob_WB_data2 !== (16'h1000 + 16'(exp_t[2 * i + 1]))) begin
        failures++; $display("FAIL drain_p2 i=%0d en=%b t=%0d d=%h exp t=%0d", i, rob_WB_en2, rob_WB_target2, rob_WB_data2, exp_t[2 * i + 1]);
      end
      checks++; if (q_count !== exp_c[i]) begin
        failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, q_count, exp_c[i]);
      end
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
      end
    end
    tick();
    checks++; if (rob_WB_en1 !== 1'b0 || rob_WB_en2 !== 1'b0 || q_empty !== 1'b1) begin
      failures++; $display("FAIL drain_after en1=%b en2=%b empty=%b exp 0 0 1", rob_WB_en1, rob_WB_en2, q_empty);
    end
  endtask

  task automatic test_mid_reset();
    wb_stall = 1'b1;
    drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd22, 16'h0022);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(23 + 2 * k), 16'h0023 + 16'(2 * k), 1'b1, 5'(24 + 2 * k), 16'h0024 + 16'(2 * k));
      tick();
    end
    idle();
    checks++; if (q_count !== 4'd7 || in_ready !== 1'b0) begin
      failures++; $display("FAIL seven_state count=%0d ready=%b exp 7 0", q_count, in_ready);
    end
    wb_stall = 1'b0;
    tick();
    checks++; if (q_count !== 4'd5 || rob_WB_target1 !== 5'd22 || rob_WB_target2 !== 5'd23 || rob_WB_en2 !== 1'b1) begin
      failures++; $display("FAIL pre_reset count=%0d t1=%0d t2=%0d en2=%b exp 5 22 23 1", q_count, rob_WB_target1, rob_WB_target2, rob_WB_en2);
    end
    rst = 1'b0;
    tick();
    checks++; if (q_count !== 4'd0 || rob_WB_en1 !== 1'b0 || rob_WB_en2 !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset count=%0d en1=%b en2=%b ready=%b exp 0 0 0 1", q_count, rob_WB_en1, rob_WB_en2, in_ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rob_WB_en1 !== 1'b0 || rob_WB_en2 !== 1'b0 || q_empty !== 1'b1) begin
        failures++; $display("FAIL no_stale cyc=%0d en1=%b en2=%b empty=%b exp 0 0 1", i, rob_WB_en1, rob_WB_en2, q_empty);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    wb_stall = 1'b0;
    idle();
    test_reset();
    test_dual_issue();
    test_conflict_split();
    test_x0_drop();
    test_full_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
